axi_lite_master_bridge: RTL and testbench
=========================================

AXI_LITE_MASTER_BRIDGE -- requirements
Module: axi_lite_master_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, giving the cycle limit for one outstanding transaction; used only when AXI_MASTER_TIMEOUT_EN is defined.
REQ-002 SHALL have port ACLK, input, 1, clock; all logic on posedge.
REQ-003 SHALL have port ARESETn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have core request ports: req_valid in 1, req_ready out 1, req_we in 1, req_addr in AXI_ADDR_BITS, req_wdata in AXI_DATA_BITS, req_wstrb in AXI_DATA_BITS/8.
REQ-005 SHALL have core response ports: resp_valid out 1, resp_rdata out AXI_DATA_BITS, resp_err out 1.
REQ-006 SHALL have AXI read ports: ARADDR out, ARVALID out, ARREADY in; RDATA in, RRESP in 2, RVALID in, RREADY out.
REQ-007 SHALL have AXI write ports: AWADDR out, AWVALID out, AWREADY in; WDATA out, WSTRB out, WVALID out, WREADY in; BRESP in 2, BVALID in, BREADY out.

Function
REQ-008 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR, WR_RESP; single outstanding transaction.
REQ-009 SHALL drive req_ready=1 only in IDLE; accept on req_valid&&req_ready; capture we/addr/wdata/wstrb into registers.
REQ-010 Accepted read (req_we=0) SHALL go IDLE->RD_ADDR; ARVALID=1 from next cycle, ARADDR=captured addr, held stable until ARREADY.
REQ-011 AR handshake SHALL clear ARVALID and enter RD_DATA; RREADY=1 only in RD_DATA.
REQ-012 R handshake SHALL, next cycle: resp_valid=1 for exactly one cycle, resp_rdata=RDATA, resp_err=(RRESP!=AXI_RESP_OKAY), state=IDLE (req_ready=1 same cycle).
REQ-013 Accepted write SHALL enter WR, asserting AWVALID and WVALID together next cycle with captured AWADDR/WDATA/WSTRB.
REQ-014 In WR, AWVALID and WVALID SHALL each drop independently after own handshake (aw_done/w_done flags); both in same cycle -> straight to WR_RESP.
REQ-015 When both done, SHALL enter WR_RESP with BREADY=1; BREADY=0 elsewhere.
REQ-016 B handshake SHALL, next cycle: resp_valid one-cycle pulse, resp_err=(BRESP!=AXI_RESP_OKAY), resp_rdata=0, state=IDLE.
REQ-017 RVALID outside RD_DATA and BVALID outside WR_RESP SHALL be ignored without state change.
REQ-018 All AXI and core outputs SHALL be registered; payload SHALL not change while its VALID is high.
REQ-019 New request SHALL be acceptable the cycle resp_valid is high (back-to-back).

Reset
REQ-020 ARESETn low SHALL asynchronously force state=IDLE, all VALID/READY outputs 0, resp_valid=0, resp_err=0, resp_rdata=0, ARADDR/AWADDR/WDATA=0, WSTRB=0, done flags=0.
REQ-021 Reset mid-transaction SHALL abandon it; no retry, no response pulse after release; req_ready=1 first cycle after release.

Configuration
REQ-022 With AXI_MASTER_TIMEOUT_EN defined, a counter SHALL clear on acceptance, increment each non-IDLE cycle, and on reaching TIMEOUT_CYCLES force IDLE, drop all VALID/READY, pulse resp_valid with resp_err=1, resp_rdata=0.
REQ-023 Without AXI_MASTER_TIMEOUT_EN, no counter SHALL exist; the block waits indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-024 AXI_ADDR_BITS, AXI_DATA_BITS, AXI_RESP_OKAY/SLVERR/DECERR SHALL come from package defs; FSM state enum typedef SHALL be added to defs.
REQ-025 No sub-module; FSM, capture registers and timeout counter inline.

Verification
REQ-026 Read addr 0x100, ARREADY=1, RVALID 2 cycles after AR, RDATA=0xDEADBEEF, RRESP=OKAY -> one resp_valid pulse, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-027 Write addr 0x40, wdata 0x12345678, wstrb 0xF; AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID after 3, BREADY only after both, pulse resp_err=0.
REQ-028 Read with RRESP=SLVERR -> resp_err=1; write with BRESP=DECERR -> resp_err=1.
REQ-029 Ten back-to-back reads, RREADY stalled randomly -> ARADDR stable while ARVALID, ten responses in order, no lost/duplicate pulse.
REQ-030 ARESETn asserted in WR_RESP -> all outputs 0 immediately; later BVALID ignored; req_ready=1 after release.
REQ-031 AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never raises ARREADY -> resp_valid with resp_err=1 exactly 8 cycles after acceptance, ARVALID=0.

Source files
------------

// File: rtl/axi_lite_master_bridge_pkg.sv
// Shared definitions for the AXI-Lite master bridge.
// Holds bus widths, AXI response codes and the bridge FSM state type.
package axi_lite_master_bridge_pkg;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP
    } bridge_state_e;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Core-request to AXI-Lite master bridge with one outstanding transaction.
// Every AXI and core output is a flop. Each flop is loaded from the next-state
// decode, so the outputs line up with the state register without a comb path.
// Optional feature: define AXI_MASTER_TIMEOUT_EN to abort any transaction that
// is still outstanding TIMEOUT_CYCLES cycles after acceptance. The abort
// returns an error response.
module axi_lite_master_bridge
    import axi_lite_master_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    // core request
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [AXI_ADDR_BITS-1:0]   req_addr,
    input  logic [AXI_DATA_BITS-1:0]   req_wdata,
    input  logic [AXI_DATA_BITS/8-1:0] req_wstrb,
    // core response
    output logic                       resp_valid,
    output logic [AXI_DATA_BITS-1:0]   resp_rdata,
    output logic                       resp_err,
    // AXI read channels
    output logic [AXI_ADDR_BITS-1:0]   ARADDR,
    output logic                       ARVALID,
    input  logic                       ARREADY,
    input  logic [AXI_DATA_BITS-1:0]   RDATA,
    input  logic [1:0]                 RRESP,
    input  logic                       RVALID,
    output logic                       RREADY,
    // AXI write channels
    output logic [AXI_ADDR_BITS-1:0]   AWADDR,
    output logic                       AWVALID,
    input  logic                       AWREADY,
    output logic [AXI_DATA_BITS-1:0]   WDATA,
    output logic [AXI_DATA_BITS/8-1:0] WSTRB,
    output logic                       WVALID,
    input  logic                       WREADY,
    input  logic [1:0]                 BRESP,
    input  logic                       BVALID,
    output logic                       BREADY
);

    bridge_state_e              state_q, state_d;
    logic                       aw_done_q, aw_done_d;
    logic                       w_done_q, w_done_d;
    logic                       resp_fire;
    logic                       resp_err_d;
    logic [AXI_DATA_BITS-1:0]   resp_rdata_d;
    logic                       accept;
    logic                       timeout;

    assign accept = req_valid && req_ready;

    // A zero limit would abort a transaction on the same edge that accepts it.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts busy cycles since acceptance. It fires on the TIMEOUT_CYCLES-th busy edge.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            tmo_cnt <= '0;
        else if (accept)
            tmo_cnt <= '0;
        else if (state_q != IDLE)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign timeout = (state_q != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register and per-channel write completion flags.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state decode, plus the response that the current cycle produces.
    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_fire    = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = req_we ? WR : RD_ADDR;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            RD_ADDR: begin
                if (ARVALID && ARREADY)
                    state_d = RD_DATA;
            end
            RD_DATA: begin
                if (RVALID && RREADY) begin
                    state_d      = IDLE;
                    resp_fire    = 1'b1;
                    resp_err_d   = (RRESP != AXI_RESP_OKAY);
                    resp_rdata_d = RDATA;
                end
            end
            WR: begin
                aw_done_d = aw_done_q || (AWVALID && AWREADY);
                w_done_d  = w_done_q  || (WVALID && WREADY);
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_RESP: begin
                if (BVALID && BREADY) begin
                    state_d    = IDLE;
                    resp_fire  = 1'b1;
                    resp_err_d = (BRESP != AXI_RESP_OKAY);
                end
            end
            default: state_d = IDLE;
        endcase
        // An abort overrides any handshake that completes on the same cycle.
        if (timeout) begin
            state_d      = IDLE;
            aw_done_d    = 1'b0;
            w_done_d     = 1'b0;
            resp_fire    = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
        end
    end

    // Handshake outputs are flops loaded from the next-state decode.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            req_ready  <= 1'b0;
            ARVALID    <= 1'b0;
            RREADY     <= 1'b0;
            AWVALID    <= 1'b0;
            WVALID     <= 1'b0;
            BREADY     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            req_ready  <= (state_d == IDLE);
            ARVALID    <= (state_d == RD_ADDR);
            RREADY     <= (state_d == RD_DATA);
            AWVALID    <= (state_d == WR) && !aw_done_d;
            WVALID     <= (state_d == WR) && !w_done_d;
            BREADY     <= (state_d == WR_RESP);
            resp_valid <= resp_fire;
            if (resp_fire) begin
                resp_err   <= resp_err_d;
                resp_rdata <= resp_rdata_d;
            end
        end
    end

    // Payload is captured only at acceptance, so it cannot move while its VALID is high.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ARADDR <= '0;
            AWADDR <= '0;
            WDATA  <= '0;
            WSTRB  <= '0;
        end else if (accept) begin
            if (req_we) begin
                AWADDR <= req_addr;
                WDATA  <= req_wdata;
                WSTRB  <= req_wstrb;
            end else begin
                ARADDR <= req_addr;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed testbench for axi_lite_master_bridge. Define AXI_MASTER_TIMEOUT_EN
// on both the bench and the RTL to run the abort scenario with an 8-cycle limit.
module tb_axi_lite_master_bridge;
    import axi_lite_master_bridge_pkg::*;

    localparam int AW = AXI_ADDR_BITS;
    localparam int DW = AXI_DATA_BITS;
    localparam int SW = AXI_DATA_BITS / 8;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_wstrb = '0;
    logic          resp_valid, resp_err;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] ARADDR, AWADDR;
    logic          ARVALID, ARREADY = 1'b0;
    logic [DW-1:0] RDATA = '0;
    logic [1:0]    RRESP = 2'b00;
    logic          RVALID = 1'b0, RREADY;
    logic          AWVALID, AWREADY = 1'b0;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WVALID, WREADY = 1'b0;
    logic [1:0]    BRESP = 2'b00;
    logic          BVALID = 1'b0, BREADY;

    int n_chk = 0;
    int n_fail = 0;
    int pulse_cnt = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_master_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    // Counts response pulses so that a lost or duplicated one shows up in the totals.
    always @(negedge ACLK) if (ARESETn && resp_valid) pulse_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one read. It starts at a negedge with the bridge idle and returns on the
    // negedge where resp_valid is expected high, so the next call can go back-to-back.
    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [1:0] rresp, input int ar_dly, input int r_dly,
                           input string tag);
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wdata = $urandom; req_wstrb = '1;
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        @(negedge ACLK);
        req_valid = 1'b0;
        for (int i = 0; i < ar_dly; i++) begin
            chk({tag, "_arvalid_hold"}, 64'(ARVALID), 64'd1);
            chk({tag, "_araddr_stable"}, 64'(ARADDR), 64'(addr));
            chk({tag, "_no_stray_resp"}, 64'(resp_valid), 64'd0);
            @(negedge ACLK);
        end
        chk({tag, "_arvalid"}, 64'(ARVALID), 64'd1);
        chk({tag, "_araddr"}, 64'(ARADDR), 64'(addr));
        chk({tag, "_rready_in_ar"}, 64'(RREADY), 64'd0);
        ARREADY = 1'b1;
        @(negedge ACLK);
        ARREADY = 1'b0;
        chk({tag, "_arvalid_drop"}, 64'(ARVALID), 64'd0);
        chk({tag, "_rready"}, 64'(RREADY), 64'd1);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge ACLK);
            chk({tag, "_rready_hold"}, 64'(RREADY), 64'd1);
        end
        RVALID = 1'b1; RDATA = data; RRESP = rresp;
        @(negedge ACLK);
        RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'(data));
        chk({tag, "_resp_err"}, 64'(resp_err), 64'(rresp != AXI_RESP_OKAY));
        chk({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_rready_off"}, 64'(RREADY), 64'd0);
    endtask

    // Runs one write. AWREADY rises aw_dly cycles after AWVALID and WREADY rises
    // w_dly cycles after WVALID. With stop_at_b set it returns in WR_RESP.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input logic [1:0] bresp,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input bit stop_at_b, input string tag);
        int mx;
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data; req_wstrb = strb;
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        @(negedge ACLK);
        req_valid = 1'b0; req_we = 1'b0;
        for (int c = 0; c <= mx; c++) begin
            chk({tag, "_awvalid"}, 64'(AWVALID), 64'(c <= aw_dly));
            chk({tag, "_wvalid"}, 64'(WVALID), 64'(c <= w_dly));
            if (c <= aw_dly) chk({tag, "_awaddr"}, 64'(AWADDR), 64'(addr));
            if (c <= w_dly) begin
                chk({tag, "_wdata"}, 64'(WDATA), 64'(data));
                chk({tag, "_wstrb"}, 64'(WSTRB), 64'(strb));
            end
            chk({tag, "_bready_early"}, 64'(BREADY), 64'd0);
            AWREADY = (c == aw_dly);
            WREADY  = (c == w_dly);
            @(negedge ACLK);
        end
        AWREADY = 1'b0; WREADY = 1'b0;
        chk({tag, "_awvalid_off"}, 64'(AWVALID), 64'd0);
        chk({tag, "_wvalid_off"}, 64'(WVALID), 64'd0);
        chk({tag, "_bready"}, 64'(BREADY), 64'd1);
        if (!stop_at_b) begin
            for (int i = 0; i < b_dly; i++) begin
                @(negedge ACLK);
                chk({tag, "_bready_hold"}, 64'(BREADY), 64'd1);
            end
            BVALID = 1'b1; BRESP = bresp;
            @(negedge ACLK);
            BVALID = 1'b0; BRESP = 2'b00;
            chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
            chk({tag, "_resp_err"}, 64'(resp_err), 64'(bresp != AXI_RESP_OKAY));
            chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
            chk({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
            chk({tag, "_bready_off"}, 64'(BREADY), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        // reset state
        repeat (3) @(negedge ACLK);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_arvalid", 64'(ARVALID), 64'd0);
        chk("rst_awvalid", 64'(AWVALID), 64'd0);
        chk("rst_wvalid", 64'(WVALID), 64'd0);
        chk("rst_rready", 64'(RREADY), 64'd0);
        chk("rst_bready", 64'(BREADY), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_araddr", 64'(ARADDR), 64'd0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);

        // basic read, then basic write with AWREADY late and WREADY immediate
        do_read(32'h0000_0100, 32'hDEAD_BEEF, AXI_RESP_OKAY, 0, 1, "rd_ok");
        @(negedge ACLK);
        chk("rd_ok_single_pulse", 64'(resp_valid), 64'd0);
        do_write(32'h0000_0040, 32'h1234_5678, 4'hF, AXI_RESP_OKAY, 2, 0, 1, 1'b0, "wr_ok");
        @(negedge ACLK);
        chk("wr_ok_single_pulse", 64'(resp_valid), 64'd0);

        // error responses, issued back-to-back
        do_read(32'h0000_0104, 32'hCAFE_F00D, AXI_RESP_SLVERR, 1, 0, "rd_slverr");
        do_write(32'h0000_0048, 32'hA5A5_5A5A, 4'h3, AXI_RESP_DECERR, 0, 2, 0, 1'b0, "wr_decerr");
        @(negedge ACLK);
        chk("wr_decerr_single_pulse", 64'(resp_valid), 64'd0);

        // stray R/B valids while idle
        RVALID = 1'b1; BVALID = 1'b1; RDATA = 32'h5555_AAAA;
        repeat (3) begin
            @(negedge ACLK);
            chk("stray_req_ready", 64'(req_ready), 64'd1);
            chk("stray_resp_valid", 64'(resp_valid), 64'd0);
        end
        RVALID = 1'b0; BVALID = 1'b0; RDATA = '0;
        @(negedge ACLK);

        // ten back-to-back reads with random stalls
        p0 = pulse_cnt;
        for (int i = 0; i < 10; i++)
            do_read(32'h0000_0200 + 32'(4 * i), 32'h1000_0000 + 32'(i), AXI_RESP_OKAY,
                    $urandom_range(0, 2), $urandom_range(0, 3), "b2b");
        @(negedge ACLK);
        chk("b2b_pulse_count", 64'(pulse_cnt - p0), 64'd10);

        // a long AR stall must not produce any response without a timeout
`ifndef AXI_MASTER_TIMEOUT_EN
        do_read(32'h0000_0300, 32'h0BAD_F00D, AXI_RESP_OKAY, 12, 0, "long_stall");
        @(negedge ACLK);
`endif

        // reset while in WR_RESP
        do_write(32'h0000_0080, 32'h7777_8888, 4'hC, AXI_RESP_OKAY, 0, 0, 0, 1'b1, "wr_rst");
        #2 ARESETn = 1'b0;
        #1;
        chk("rst_mid_bready", 64'(BREADY), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mid_awaddr", 64'(AWADDR), 64'd0);
        chk("rst_mid_wdata", 64'(WDATA), 64'd0);
        chk("rst_mid_wstrb", 64'(WSTRB), 64'd0);
        BVALID = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("rst_rel_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rel_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rel_bready", 64'(BREADY), 64'd0);
        @(negedge ACLK);
        chk("rst_rel_no_pulse", 64'(resp_valid), 64'd0);
        BVALID = 1'b0;
        @(negedge ACLK);

`ifdef AXI_MASTER_TIMEOUT_EN
        // the slave never raises ARREADY, so the bridge aborts 8 cycles after acceptance
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0500;
        chk("tmo_req_ready", 64'(req_ready), 64'd1);
        @(negedge ACLK);
        req_valid = 1'b0;
        chk("tmo_arvalid", 64'(ARVALID), 64'd1);
        repeat (7) begin
            @(negedge ACLK);
            chk("tmo_no_early_resp", 64'(resp_valid), 64'd0);
        end
        @(negedge ACLK);
        chk("tmo_resp_valid", 64'(resp_valid), 64'd1);
        chk("tmo_resp_err", 64'(resp_err), 64'd1);
        chk("tmo_resp_rdata", 64'(resp_rdata), 64'd0);
        chk("tmo_arvalid_off", 64'(ARVALID), 64'd0);
        chk("tmo_req_ready_back", 64'(req_ready), 64'd1);
        @(negedge ACLK);
        chk("tmo_single_pulse", 64'(resp_valid), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
